// File: rtl/partition_pointer_unit.sv
// Hoare partition pointer engine: up-counting i and down-counting j converge over [lo, hi].
// Latency: start to done is 4 cycles minimum (1 cycle when lo >= hi), plus scan steps and swap waits.
// Backpressure: swap_req is held until swap_done is sampled; start is ignored while busy.
module partition_pointer_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] lo,
  input  logic [ADDR_W-1:0] hi,
  input  logic              lt_pivot,
  input  logic              gt_pivot,
  input  logic              swap_done,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic              swap_req,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] split,
  output logic [ADDR_W-1:0] swap_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN_I = 3'd1,
    S_SCAN_J = 3'd2,
    S_CHECK  = 3'd3,
    S_SWAP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_i;
  logic [ADDR_W-1:0] r_j;
  logic [ADDR_W-1:0] r_split;
  logic [ADDR_W-1:0] r_swap_cnt;
  logic [ADDR_W-1:0] w_i_nxt;
  logic [ADDR_W-1:0] w_j_nxt;
  logic [ADDR_W-1:0] w_split_nxt;
  logic [ADDR_W-1:0] w_swap_cnt_nxt;
  logic              w_swap_req;
  logic              w_done;

  // State and datapath registers; reset abandons any partition in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_split    <= '0;
      r_swap_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_i        <= w_i_nxt;
      r_j        <= w_j_nxt;
      r_split    <= w_split_nxt;
      r_swap_cnt <= w_swap_cnt_nxt;
    end
  end

  // Next-state, pointer updates and Moore outputs; everything holds unless a transition moves it.
  always_comb begin
    w_state_nxt    = r_state;
    w_i_nxt        = r_i;
    w_j_nxt        = r_j;
    w_split_nxt    = r_split;
    w_swap_cnt_nxt = r_swap_cnt;
    w_swap_req     = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_i_nxt        = lo;
          w_j_nxt        = hi;
          w_swap_cnt_nxt = '0;
          if (lo >= hi) begin
            // Zero- or one-element range: already partitioned.
            w_split_nxt = lo;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SCAN_I;
          end
        end
      end
      S_SCAN_I: begin
        if (lt_pivot) w_i_nxt = r_i + ONE;
        else          w_state_nxt = S_SCAN_J;
      end
      S_SCAN_J: begin
        if (gt_pivot) w_j_nxt = r_j - ONE;
        else          w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (r_i >= r_j) begin
          w_split_nxt = r_j;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SWAP;
        end
      end
      S_SWAP: begin
        w_swap_req = 1'b1;
        if (swap_done) begin
          // i < j held on entry, so neither step can leave [lo, hi].
          w_i_nxt = r_i + ONE;
          w_j_nxt = r_j - ONE;
          if (r_swap_cnt != '1) w_swap_cnt_nxt = r_swap_cnt + ONE;
          w_state_nxt = S_SCAN_I;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign addr_i     = r_i;
  assign addr_j     = r_j;
  assign split      = r_split;
  assign swap_count = r_swap_cnt;
  assign swap_req   = w_swap_req;
  assign done       = w_done;
  assign busy       = (r_state != S_IDLE);

endmodule
